// File: rtl/multicycle_control_if.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_if
// Description : Bundles the signals between the multi-cycle sequencer and the
//               RV32 datapath/memory side.
//               master : datapath side. Drives run request, IR opcode and
//                        memory ready. Receives all control strobes.
//               slave  : sequencer side (multicycle_control).
//               Ports carried:
//                 enable, opcode[6:0], mem_ready            (master -> slave)
//                 pc_write, pc_write_cond, pc_source, i_or_d, ir_write,
//                 mem_read, mem_write, reg_write, mem_to_reg, alu_src_a,
//                 alu_src_b[1:0], alu_op[1:0], illegal_op, instr_done,
//                 retired[CNT_W-1:0], state[3:0]            (slave -> master)
//               CNT_W must match the CNT_W of the attached sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_control_if #(
    parameter int CNT_W = 32
);
    logic             enable;
    logic [6:0]       opcode;
    logic             mem_ready;

    logic             pc_write;
    logic             pc_write_cond;
    logic             pc_source;
    logic             i_or_d;
    logic             ir_write;
    logic             mem_read;
    logic             mem_write;
    logic             reg_write;
    logic             mem_to_reg;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic             illegal_op;
    logic             instr_done;
    logic [CNT_W-1:0] retired;
    logic [3:0]       state;

    modport master (
        output enable, opcode, mem_ready,
        input  pc_write, pc_write_cond, pc_source, i_or_d, ir_write,
               mem_read, mem_write, reg_write, mem_to_reg, alu_src_a,
               alu_src_b, alu_op, illegal_op, instr_done, retired, state
    );

    modport slave (
        input  enable, opcode, mem_ready,
        output pc_write, pc_write_cond, pc_source, i_or_d, ir_write,
               mem_read, mem_write, reg_write, mem_to_reg, alu_src_a,
               alu_src_b, alu_op, illegal_op, instr_done, retired, state
    );
endinterface : multicycle_control_if
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control
// Description : Multi-cycle sequencer for the RV32 datapath. Steps R-type,
//               load, store and beq through FETCH/DECODE/execute/write-back
//               states, stalls on the memory ready handshake, flags
//               unsupported opcodes and counts retired instructions.
// Ports       : clk   - system clock, rising edge
//               reset - asynchronous, active-high
//               bus   - multicycle_control_if.slave (enable, opcode,
//                       mem_ready in; datapath control strobes, illegal_op,
//                       instr_done, retired count and debug state out)
// Parameters  : CNT_W - width of the retired-instruction counter
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control #(
    parameter int CNT_W = 32
) (
    input  wire logic           clk,
    input  wire logic           reset,
    multicycle_control_if.slave bus
);

    // ------------------------------------------------------------------------
    // State encoding (also exported on bus.state for debug)
    // ------------------------------------------------------------------------
    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXECUTE   = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9
    } t_state;

    localparam logic [6:0] c_OP_RTYPE = 7'b0110011;
    localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
    localparam logic [6:0] c_OP_STORE = 7'b0100011;
    localparam logic [6:0] c_OP_BEQ   = 7'b1100011;

    localparam logic [1:0] c_SRCB_RS2  = 2'b00;
    localparam logic [1:0] c_SRCB_FOUR = 2'b01;
    localparam logic [1:0] c_SRCB_IMM  = 2'b10;
    localparam logic [1:0] c_SRCB_BOFF = 2'b11;

    localparam logic [1:0] c_ALU_ADD   = 2'b00;
    localparam logic [1:0] c_ALU_SUB   = 2'b01;
    localparam logic [1:0] c_ALU_FUNCT = 2'b10;

    // Moore part of the control word. It is registered alongside the state
    // by decoding the next state, so it always describes r_state.
    typedef struct packed {
        logic       pc_write_cond;
        logic       pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       done;
    } t_ctl;

    function automatic t_ctl f_moore(input t_state s);
        t_ctl c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = c_SRCB_FOUR;
                c.alu_op    = c_ALU_ADD;
            end
            S_DECODE: begin
                // Branch target is precomputed into ALUOut here.
                c.alu_src_b = c_SRCB_BOFF;
                c.alu_op    = c_ALU_ADD;
            end
            S_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = c_SRCB_IMM;
                c.alu_op    = c_ALU_ADD;
            end
            S_MEM_READ: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                c.done       = 1'b1;
            end
            S_MEM_WRITE: begin
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
            end
            S_EXECUTE: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = c_SRCB_RS2;
                c.alu_op    = c_ALU_FUNCT;
            end
            S_ALU_WB: begin
                c.reg_write = 1'b1;
                c.done      = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_src_b     = c_SRCB_RS2;
                c.alu_op        = c_ALU_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 1'b1;
                c.done          = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // ------------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------------
    t_state           r_state;
    t_ctl             r_ctl;
    logic             r_is_load;   // load vs store, captured in DECODE
    logic [CNT_W-1:0] r_retired;

    t_state           w_next;
    t_state           w_complete;  // where a finished instruction goes
    logic             w_legal;
    logic             w_fetch_ack;
    logic             w_write_ack;
    logic             w_done;

    always_comb begin
        w_legal     = (bus.opcode == c_OP_RTYPE) || (bus.opcode == c_OP_LOAD) ||
                      (bus.opcode == c_OP_STORE) || (bus.opcode == c_OP_BEQ);
        w_fetch_ack = (r_state == S_FETCH) && bus.mem_ready;
        w_write_ack = (r_state == S_MEM_WRITE) && bus.mem_ready;
        // Write-back and branch states complete unconditionally; a store
        // completes on the cycle memory accepts the write.
        w_done      = r_ctl.done || w_write_ack;
        w_complete  = bus.enable ? S_FETCH : S_IDLE;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.enable) begin
                    w_next = S_FETCH;
                end
            end
            S_FETCH: begin
                if (bus.mem_ready) begin
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                case (bus.opcode)
                    c_OP_RTYPE: w_next = S_EXECUTE;
                    c_OP_LOAD:  w_next = S_MEM_ADDR;
                    c_OP_STORE: w_next = S_MEM_ADDR;
                    c_OP_BEQ:   w_next = S_BRANCH;
                    // Unsupported opcode: skip it and fetch the next word.
                    default:    w_next = S_FETCH;
                endcase
            end
            S_MEM_ADDR: begin
                w_next = r_is_load ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                if (bus.mem_ready) begin
                    w_next = S_MEM_WB;
                end
            end
            S_MEM_WRITE: begin
                if (bus.mem_ready) begin
                    w_next = w_complete;
                end
            end
            S_EXECUTE: begin
                w_next = S_ALU_WB;
            end
            S_MEM_WB,
            S_ALU_WB,
            S_BRANCH: begin
                w_next = w_complete;
            end
            default: begin
                // Unused encodings recover to IDLE.
                w_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Sequencer state, registered Moore controls and retire counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_ctl     <= '0;
            r_is_load <= 1'b0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            r_ctl   <= f_moore(w_next);
            if (r_state == S_DECODE) begin
                r_is_load <= (bus.opcode == c_OP_LOAD);
            end
            if (w_done) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: registered Moore terms plus the handshake-dependent terms
    // ------------------------------------------------------------------------
    assign bus.pc_write      = w_fetch_ack;
    assign bus.ir_write      = w_fetch_ack;
    assign bus.pc_write_cond = r_ctl.pc_write_cond;
    assign bus.pc_source     = r_ctl.pc_source;
    assign bus.i_or_d        = r_ctl.i_or_d;
    assign bus.mem_read      = r_ctl.mem_read;
    assign bus.mem_write     = r_ctl.mem_write;
    assign bus.reg_write     = r_ctl.reg_write;
    assign bus.mem_to_reg    = r_ctl.mem_to_reg;
    assign bus.alu_src_a     = r_ctl.alu_src_a;
    assign bus.alu_src_b     = r_ctl.alu_src_b;
    assign bus.alu_op        = r_ctl.alu_op;
    assign bus.illegal_op    = (r_state == S_DECODE) && !w_legal;
    assign bus.instr_done    = w_done;
    assign bus.retired       = r_retired;
    assign bus.state         = r_state;

endmodule : multicycle_control
`default_nettype wire

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle sequencer FSM for the RV32 datapath. Drives PC, IR, memory, ALU-mux and register-file enables state by state for R-type, load (0000011), store (0100011) and beq (1100011).
- Handles variable-latency memory through a ready handshake.
- Flags unsupported opcodes and counts retired instructions.
- Sits beside the datapath. The opcode comes from the datapath IR, which loads on ir_write.

Parameters:
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
enable  input  1  run request; sampled only in IDLE and at instruction completion
opcode  input  7  IR[6:0]; sampled in DECODE only
mem_ready  input  1  memory access complete this cycle
pc_write  output  1  unconditional PC load
pc_write_cond  output  1  PC load if datapath zero flag = 1 (beq)
pc_source  output  1  0 = ALU result (PC+4), 1 = ALUOut register (branch target)
i_or_d  output  1  memory address select: 0 = PC, 1 = ALUOut
ir_write  output  1  IR load
mem_read  output  1  memory read request
mem_write  output  1  memory write request
reg_write  output  1  register-file write
mem_to_reg  output  1  write-back select: 0 = ALUOut, 1 = MDR
alu_src_a  output  1  0 = PC, 1 = rs1
alu_src_b  output  2  00 = rs2, 01 = constant 4, 10 = imm, 11 = branch offset (imm<<1)
alu_op  output  2  00 = add, 01 = subtract (beq), 10 = decode funct fields
illegal_op  output  1  one-cycle pulse in DECODE for an unsupported opcode
instr_done  output  1  one-cycle pulse in the final state of a legal instruction
retired  output  CNT_W  count of completed legal instructions
state  output  4  current state encoding, for debug

Behaviour:
- States and encodings: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6, EXECUTE=7, ALU_WB=8, BRANCH=9. Codes 10-15 go to IDLE on the next edge.
- Reset (async, any time, including mid-instruction or a pending memory access): state=IDLE, retired=0.
  - In IDLE every control output is 0, including the pulses.
  - No X is ever driven on any output in any state.
- Outputs are Moore-decoded from state. The exceptions are the Mealy terms noted below. Any output not listed for a state is 0.
- IDLE: go to FETCH if enable=1, else stay.
- FETCH:
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=0.
  - ir_write=pc_write=mem_ready (Mealy).
  - Stay in FETCH while mem_ready=0. Go to DECODE when mem_ready=1.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precomputed into ALUOut).
  - Next state by opcode: 0110011 -> EXECUTE; 0000011 or 0100011 -> MEM_ADDR; 1100011 -> BRANCH.
  - Any other opcode: illegal_op=1 (Mealy on opcode), next state FETCH. No register or memory write. retired does not change.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Load -> MEM_READ, store -> MEM_WRITE. The opcode is held stable by the IR.
- MEM_READ: mem_read=1, i_or_d=1. Stay while mem_ready=0. Go to MEM_WB when mem_ready=1.
- MEM_WB: reg_write=1, mem_to_reg=1, instr_done=1.
- MEM_WRITE: mem_write=1, i_or_d=1. Stay while mem_ready=0. When mem_ready=1: instr_done=1 (Mealy), instruction completes.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10, then go to ALU_WB.
- ALU_WB: reg_write=1, mem_to_reg=0, instr_done=1.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=1, instr_done=1.
- Completion, i.e. any cycle with instr_done=1:
  - retired increments by 1 on that edge and wraps modulo 2^CNT_W.
  - Next state is FETCH if enable=1, else IDLE.
- An enable drop mid-instruction has no effect until completion.
- Cycle counts with mem_ready always 1: R-type 4, load 5, store 4, beq 3, illegal 2.
  - Each memory wait cycle adds 1 cycle in FETCH, MEM_READ or MEM_WRITE.

Test Plan:
- Reset then enable=1, opcode=0110011, mem_ready=1 -> states 1,2,7,8,1; reg_write=1 only in state 8; alu_op=10 in state 7; retired=1.
- Load 0000011 with mem_ready low for 2 cycles in MEM_READ -> mem_read and i_or_d held 3 cycles; MEM_WB asserts reg_write=1, mem_to_reg=1; 7 cycles total; retired +1.
- beq 1100011 -> DECODE shows alu_src_b=11; BRANCH shows pc_write_cond=1, pc_source=1, alu_op=01; back to FETCH after 3 cycles.
- opcode=1111111 -> illegal_op pulse in DECODE, then FETCH; no reg_write or mem_write; retired unchanged.
- Store with enable dropped during MEM_ADDR -> mem_write asserted until mem_ready, instr_done pulses, then IDLE with all outputs 0.
- Assert reset mid-MEM_WRITE -> same cycle: state=0, mem_write=0, retired=0; retired wraps to 0 after 2^CNT_W completions (CNT_W=4, 16 R-types).
